// File: rtl/warp_issue_tracker.sv
// warp_issue_tracker: per-warp issue eligibility, grant cooldown and outstanding memory-op tracking
module warp_issue_tracker #(
    parameter int NUM_WARPS_PER_SM = 4,
    parameter int ISSUE_LATENCY    = 3,
    parameter int MAX_PENDING      = 3,
    localparam int IDX_W  = (NUM_WARPS_PER_SM > 1) ? $clog2(NUM_WARPS_PER_SM) : 1,
    localparam int PEND_W = $clog2(MAX_PENDING + 1)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_WARPS_PER_SM-1:0]        warp_enable,
    input  logic [NUM_WARPS_PER_SM-1:0]        stall,
    output logic [NUM_WARPS_PER_SM-1:0]        request,
    input  logic [NUM_WARPS_PER_SM-1:0]        grantOH,
    input  logic                               grant_is_mem,
    input  logic                               mem_done_valid,
    input  logic [IDX_W-1:0]                   mem_done_warp,
    output logic                               issue_valid,
    output logic [IDX_W-1:0]                   issue_warp,
    output logic                               err_grant,
    output logic                               err_done,
    output logic [NUM_WARPS_PER_SM*PEND_W-1:0] pending_cnt,
    output logic                               sm_idle
);
    localparam int N = NUM_WARPS_PER_SM;
    localparam int CNT_W = (ISSUE_LATENCY > 2) ? $clog2(ISSUE_LATENCY) : 1;
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'((ISSUE_LATENCY > 1) ? ISSUE_LATENCY - 2 : 0);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    typedef enum logic [1:0] {IDLE, READY, COOL} state_t;

    state_t            state_q [N];
    state_t            state_d [N];
    logic [CNT_W-1:0]  cnt_q [N];
    logic [CNT_W-1:0]  cnt_d [N];
    logic [PEND_W-1:0] pend_q [N];
    logic [PEND_W-1:0] pend_d [N];
    logic              issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0]  issue_warp_q, issue_warp_d;
    logic              err_grant_q, err_grant_d;
    logic              err_done_q, err_done_d;
    logic              sm_idle_q, sm_idle_d;
    logic              grant_ok, done_ok, g, d, m;

    // request is a function of registered state and stall only, never of grantOH
    always_comb begin
        request = '0;
        for (int i = 0; i < N; i++) begin
            request[i] = (state_q[i] == READY) & ~stall[i] & (pend_q[i] < PEND_MAX);
            pending_cnt[i*PEND_W +: PEND_W] = pend_q[i];
        end
    end

    // validate the grant, update per-warp FSMs, cooldowns and pending counters
    always_comb begin
        grant_ok = ((grantOH & (grantOH - N'(1))) == '0) && ((grantOH & ~request) == '0);
        done_ok = mem_done_valid && (32'(mem_done_warp) < N) && (pend_q[mem_done_warp] != '0);
        issue_valid_d = grant_ok && (grantOH != '0);
        issue_warp_d = '0;
        err_grant_d = !grant_ok;
        err_done_d = mem_done_valid && !done_ok;
        sm_idle_d = 1'b1;
        g = 1'b0;
        d = 1'b0;
        m = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grantOH[i]) issue_warp_d = IDX_W'(i);
            g = issue_valid_d && grantOH[i];
            m = g && grant_is_mem;
            d = done_ok && (32'(mem_done_warp) == i);
            pend_d[i] = (m && !d) ? pend_q[i] + PEND_W'(1) :
                        (d && !m) ? pend_q[i] - PEND_W'(1) : pend_q[i];
            state_d[i] = !warp_enable[i] ? IDLE :
                         g ? ((ISSUE_LATENCY == 1) ? READY : COOL) :
                         (state_q[i] == IDLE || (state_q[i] == COOL && cnt_q[i] == '0)) ? READY :
                         state_q[i];
            cnt_d[i] = !warp_enable[i] ? '0 :
                       g ? COOL_LOAD :
                       (state_q[i] == COOL && cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
            if (state_d[i] != IDLE || pend_d[i] != '0) sm_idle_d = 1'b0;
        end
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                pend_q[i]  <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_warp_q  <= '0;
            err_grant_q   <= 1'b0;
            err_done_q    <= 1'b0;
            sm_idle_q     <= 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                pend_q[i]  <= pend_d[i];
            end
            issue_valid_q <= issue_valid_d;
            issue_warp_q  <= issue_warp_d;
            err_grant_q   <= err_grant_d;
            err_done_q    <= err_done_d;
            sm_idle_q     <= sm_idle_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_warp  = issue_warp_q;
    assign err_grant   = err_grant_q;
    assign err_done    = err_done_q;
    assign sm_idle     = sm_idle_q;
endmodule

// File: tb/tb_warp_issue_tracker.sv
// tb_warp_issue_tracker: randomized and directed checks against a cycle-level reference model
module tb_warp_issue_tracker;
    localparam int LAT = 3;
    localparam int MAXP = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] warp_enable, stall, grantOH, request;
    logic       grant_is_mem, mem_done_valid;
    logic [1:0] mem_done_warp, issue_warp;
    logic       issue_valid, err_grant, err_done, sm_idle;
    logic [7:0] pending_cnt;

    warp_issue_tracker #(.NUM_WARPS_PER_SM(4), .ISSUE_LATENCY(LAT), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .reset_n(reset_n), .warp_enable(warp_enable), .stall(stall),
        .request(request), .grantOH(grantOH), .grant_is_mem(grant_is_mem),
        .mem_done_valid(mem_done_valid), .mem_done_warp(mem_done_warp),
        .issue_valid(issue_valid), .issue_warp(issue_warp), .err_grant(err_grant),
        .err_done(err_done), .pending_cnt(pending_cnt), .sm_idle(sm_idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;
    bit en_prev [4];
    int last_g [4];
    int pend [4];
    logic m_iv, m_eg, m_ed, m_idle;
    logic [1:0] m_iw;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, k);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            en_prev[i] = 0;
            last_g[i] = -1000;
            pend[i] = 0;
        end
        m_iv = 0; m_iw = 0; m_eg = 0; m_ed = 0; m_idle = 1;
    endtask

    // a warp may request once it was enabled at the last edge, its cooldown window has elapsed and it has room for another memory op
    function automatic logic [3:0] mreq(input logic [3:0] st);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++)
            r[i] = en_prev[i] && (k >= last_g[i] + LAT) && !st[i] && (pend[i] < MAXP);
        return r;
    endfunction

    function automatic logic [7:0] mpend();
        logic [7:0] p = '0;
        for (int i = 0; i < 4; i++) p[i*2 +: 2] = 2'(pend[i]);
        return p;
    endfunction

    task automatic cyc(input logic [3:0] en, input logic [3:0] st, input logic [3:0] g,
                       input logic mem, input logic dv, input logic [1:0] dw);
        logic [3:0] r;
        logic legal, iss, dok;
        int idx;
        chk("issue_valid", 32'(issue_valid), 32'(m_iv));
        if (m_iv) chk("issue_warp", 32'(issue_warp), 32'(m_iw));
        chk("err_grant", 32'(err_grant), 32'(m_eg));
        chk("err_done", 32'(err_done), 32'(m_ed));
        chk("sm_idle", 32'(sm_idle), 32'(m_idle));
        chk("pending_cnt", 32'(pending_cnt), 32'(mpend()));
        warp_enable = en; stall = st; grantOH = g; grant_is_mem = mem;
        mem_done_valid = dv; mem_done_warp = dw;
        #1;
        r = mreq(st);
        chk("request", 32'(request), 32'(r));
        legal = ($countones(g) <= 1) && ((g & ~r) == '0);
        iss = legal && (g != '0);
        idx = 0;
        for (int i = 0; i < 4; i++) if (g[i]) idx = i;
        dok = dv && (pend[dw] > 0);
        m_iv = iss; m_iw = 2'(idx); m_eg = !legal; m_ed = dv && !dok;
        if (iss && mem) pend[idx]++;
        if (dok) pend[dw]--;
        if (iss) last_g[idx] = k;
        m_idle = (en == '0);
        for (int i = 0; i < 4; i++) begin
            if (!en[i]) last_g[i] = -1000;
            en_prev[i] = en[i];
            if (pend[i] != 0) m_idle = 0;
        end
        k++;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] en_r, st_r, g_r, rq;
    int sel, pick;

    initial begin
        reset_n = 0; warp_enable = 0; stall = 0; grantOH = 0;
        grant_is_mem = 0; mem_done_valid = 0; mem_done_warp = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_request", 32'(request), 32'h0);
        chk("rst_issue_valid", 32'(issue_valid), 32'h0);
        chk("rst_err", 32'({err_grant, err_done}), 32'h0);
        chk("rst_pending", 32'(pending_cnt), 32'h0);
        chk("rst_sm_idle", 32'(sm_idle), 32'h1);
        reset_n = 1;

        cyc(4'b0101, 0, 0, 0, 0, 0);
        chk("en_request", 32'(request), 32'h5);
        chk("en_sm_idle", 32'(sm_idle), 32'h0);

        cyc(4'b0101, 0, 4'b0001, 0, 0, 0);
        chk("cool_issue_valid", 32'(issue_valid), 32'h1);
        chk("cool_issue_warp", 32'(issue_warp), 32'h0);
        chk("cool_req0_t1", 32'(request[0]), 32'h0);
        cyc(4'b0101, 0, 0, 0, 0, 0);
        chk("cool_req0_t2", 32'(request[0]), 32'h0);
        cyc(4'b0101, 0, 0, 0, 0, 0);
        chk("cool_req0_t3", 32'(request[0]), 32'h1);

        for (int n = 0; n < 3; n++) begin
            cyc(4'b0101, 0, 4'b0100, 1, 0, 0);
            cyc(4'b0101, 0, 0, 0, 0, 0);
            cyc(4'b0101, 0, 0, 0, 0, 0);
        end
        chk("full_pending2", 32'(pending_cnt[5:4]), 32'h3);
        chk("full_req2", 32'(request[2]), 32'h0);
        cyc(4'b0101, 0, 0, 0, 1, 2'd2);
        chk("drain_pending2", 32'(pending_cnt[5:4]), 32'h2);
        chk("drain_req2", 32'(request[2]), 32'h1);

        cyc(4'b0101, 0, 4'b0011, 0, 0, 0);
        chk("multi_err_grant", 32'(err_grant), 32'h1);
        chk("multi_no_issue", 32'(issue_valid), 32'h0);
        cyc(4'b0101, 0, 4'b1000, 1, 0, 0);
        chk("noreq_err_grant", 32'(err_grant), 32'h1);
        chk("noreq_pending3", 32'(pending_cnt[7:6]), 32'h0);
        cyc(4'b0101, 0, 0, 0, 1, 2'd1);
        chk("done_err", 32'(err_done), 32'h1);
        chk("err_grant_pulse", 32'(err_grant), 32'h0);

        cyc(4'b1101, 0, 0, 0, 0, 0);
        cyc(4'b1101, 0, 4'b1000, 1, 0, 0);
        cyc(4'b1101, 0, 0, 0, 0, 0);
        cyc(4'b1101, 0, 0, 0, 0, 0);
        cyc(4'b1101, 0, 4'b1000, 1, 1, 2'd3);
        chk("same_pending3", 32'(pending_cnt[7:6]), 32'h1);
        chk("same_no_err", 32'(err_done), 32'h0);

        cyc(0, 0, 0, 0, 1, 2'd2);
        cyc(0, 0, 0, 0, 1, 2'd2);
        chk("draining_not_idle", 32'(sm_idle), 32'h0);
        cyc(0, 0, 0, 0, 1, 2'd3);
        chk("idle_sm_idle", 32'(sm_idle), 32'h1);
        chk("idle_pending", 32'(pending_cnt), 32'h0);

        en_r = 4'b1111;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 99) < 3) en_r[i] = ~en_r[i];
            st_r = 4'($urandom & $urandom);
            rq = mreq(st_r);
            sel = $urandom_range(0, 99);
            g_r = '0;
            if (sel < 10) g_r = 4'($urandom);
            else if (sel < 75 && rq != '0) begin
                do pick = $urandom_range(0, 3); while (!rq[pick]);
                g_r[pick] = 1'b1;
            end
            cyc(en_r, st_r, g_r, 1'($urandom), $urandom_range(0, 99) < 35, 2'($urandom));
        end

        cyc(4'b0001, 0, 0, 0, 0, 0);
        cyc(4'b0001, 0, 0, 0, 0, 0);
        cyc(4'b0001, 0, 0, 0, 0, 0);
        cyc(4'b0001, 0, 0, 0, 0, 0);
        cyc(4'b0001, 0, 4'b0001, 1, 0, 0);
        #2 reset_n = 0;
        #1;
        chk("arst_request", 32'(request), 32'h0);
        chk("arst_pending", 32'(pending_cnt), 32'h0);
        chk("arst_issue_valid", 32'(issue_valid), 32'h0);
        chk("arst_sm_idle", 32'(sm_idle), 32'h1);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        cyc(4'b0001, 0, 0, 0, 0, 0);
        cyc(4'b0001, 0, 0, 0, 0, 0);
        chk("post_rst_request", 32'(request), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
